// File: rtl/mux_sched_pkg.sv
// Shared types, default sizes and the pointer-advance helper for the round-robin
// output-channel scheduler.
package mux_sched_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } sched_state_t;

    localparam int DEF_NUM_CH     = 8;
    localparam int DEF_DATA_WIDTH = 32;

    // Priority pointer moves to the channel just after the one released, wrapping to 0.
    function automatic int unsigned next_ptr(input int unsigned sel, input int unsigned num_ch);
        return (sel + 1 >= num_ch) ? 0 : sel + 1;
    endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Round-robin pick: rotate requests so ptr sits at bit 0, take the lowest set bit,
// then rotate the index back into channel numbering.
module rr_priority_pick
    import mux_sched_pkg::*;
#(
    parameter int NUM_CH    = DEF_NUM_CH,
    parameter int SEL_WIDTH = $clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0]    req,
    input  logic [SEL_WIDTH-1:0] ptr,
    output logic [SEL_WIDTH-1:0] gnt_idx,
    output logic                 any_req
);

    logic [NUM_CH-1:0]    req_rot;
    logic [SEL_WIDTH-1:0] ffs;
    int                   idx_sum;

    assign req_rot = NUM_CH'({req, req} >> ptr);
    assign any_req = |req;

    always_comb begin
        ffs = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (req_rot[i]) begin
                ffs = SEL_WIDTH'(i);
            end
        end
        idx_sum = int'(ffs) + int'(ptr);
        if (idx_sum >= NUM_CH) begin
            idx_sum = idx_sum - NUM_CH;
        end
        gnt_idx = SEL_WIDTH'(idx_sum);
    end

endmodule

// File: rtl/mux_rr_scheduler.sv
// Round-robin packet scheduler sharing one registered output channel between NUM_CH
// requesters; a grant is held until the last beat or a forced release at MAX_BURST.
module mux_rr_scheduler
    import mux_sched_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int NUM_CH     = DEF_NUM_CH,
    parameter int SEL_WIDTH  = $clog2(NUM_CH),
    parameter int MAX_BURST  = 16
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    input  logic [NUM_CH-1:0]                    ch_valid_i,
    input  logic [NUM_CH-1:0][DATA_WIDTH-1:0]    ch_data_i,
    input  logic [NUM_CH-1:0]                    ch_last_i,
    output logic [NUM_CH-1:0]                    ch_ready_o,
    output logic                                 out_valid_o,
    output logic [DATA_WIDTH-1:0]                out_data_o,
    output logic                                 out_last_o,
    input  logic                                 out_ready_i,
    output logic [SEL_WIDTH-1:0]                 selector_o,
    output logic                                 busy_o
);

    localparam int                   CNT_WIDTH = $clog2(MAX_BURST + 1);
    localparam logic [CNT_WIDTH-1:0] CNT_LAST  = CNT_WIDTH'(MAX_BURST - 1);

    sched_state_t         state;
    logic [SEL_WIDTH-1:0] ptr;
    logic [CNT_WIDTH-1:0] cnt;
    logic [SEL_WIDTH-1:0] pick_idx;
    logic                 any_req;
    logic                 out_free;
    logic                 take;
    logic                 beat_last;

    rr_priority_pick #(
        .NUM_CH    (NUM_CH),
        .SEL_WIDTH (SEL_WIDTH)
    ) u_pick (
        .req     (ch_valid_i),
        .ptr     (ptr),
        .gnt_idx (pick_idx),
        .any_req (any_req)
    );

    // Handshake: a beat moves on a rising edge where valid and ready are both high;
    // ready never depends on the granted channel's own valid.
    assign out_free  = !out_valid_o || out_ready_i;
    assign take      = (state == GRANT) && ch_valid_i[selector_o] && out_free;
    assign beat_last = ch_last_i[selector_o] || (cnt == CNT_LAST);
    assign busy_o    = (state == GRANT);

    always_comb begin
        ch_ready_o = '0;
        if (state == GRANT) begin
            ch_ready_o[selector_o] = out_free;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= IDLE;
            selector_o  <= '0;
            ptr         <= '0;
            cnt         <= '0;
            out_valid_o <= 1'b0;
            out_data_o  <= '0;
            out_last_o  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        selector_o <= pick_idx;
                        state      <= GRANT;
                    end
                end
                GRANT: begin
                    if (take) begin
                        if (beat_last) begin
                            state <= IDLE;
                            cnt   <= '0;
                            ptr   <= SEL_WIDTH'(next_ptr(32'(selector_o), NUM_CH));
                        end else begin
                            cnt <= cnt + CNT_WIDTH'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase

            // Output register refills on a take, otherwise empties once accepted.
            if (take) begin
                out_valid_o <= 1'b1;
                out_data_o  <= ch_data_i[selector_o];
                out_last_o  <= beat_last;
            end else if (out_valid_o && out_ready_i) begin
                out_valid_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mux_rr_scheduler.sv
// Bench for mux_rr_scheduler: cycle model with per-channel sources, directed
// sequences, a fairness vector table and randomized traffic.
module tb_mux_rr_scheduler;

    localparam int NCH   = 8;
    localparam int DW    = 32;
    localparam int SW    = 3;
    localparam int MB    = 4;
    localparam int DEPTH = 256;

    logic                    clk = 1'b0;
    logic                    rst = 1'b1;
    logic [NCH-1:0]          ch_valid = '0;
    logic [NCH-1:0][DW-1:0]  ch_data = '0;
    logic [NCH-1:0]          ch_last = '0;
    logic [NCH-1:0]          ch_ready;
    logic                    out_valid;
    logic [DW-1:0]           out_data;
    logic                    out_last;
    logic                    out_ready = 1'b0;
    logic [SW-1:0]           selector;
    logic                    busy;

    mux_rr_scheduler #(
        .DATA_WIDTH (DW),
        .NUM_CH     (NCH),
        .SEL_WIDTH  (SW),
        .MAX_BURST  (MB)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .ch_valid_i  (ch_valid),
        .ch_data_i   (ch_data),
        .ch_last_i   (ch_last),
        .ch_ready_o  (ch_ready),
        .out_valid_o (out_valid),
        .out_data_o  (out_data),
        .out_last_o  (out_last),
        .out_ready_i (out_ready),
        .selector_o  (selector),
        .busy_o      (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int seq    = 0;

    logic [DW-1:0] src_data [NCH][DEPTH];
    logic          src_last [NCH][DEPTH];
    int            src_head [NCH];
    int            src_tail [NCH];

    logic [DW:0]   exp_q[$];
    logic [DW:0]   out_log[$];
    int            out_cyc[$];

    int m_owner = -1;
    int m_ptr   = 0;
    int m_beats = 0;
    int m_sel   = 0;
    int rdy_pct = 100;
    int vld_pct = 100;
    bit do_rst  = 1'b1;
    bit chk_sel = 1'b0;

    typedef struct {
        logic [NCH-1:0] mask;
        int             n;
        int             order[NCH];
    } vec_t;
    vec_t vecs[6];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_beat(input int ch, input logic [DW-1:0] d, input logic l);
        src_data[ch][src_tail[ch] % DEPTH] = d;
        src_last[ch][src_tail[ch] % DEPTH] = l;
        src_tail[ch]++;
    endtask

    task automatic push_packet(input int ch, input int len);
        for (int b = 0; b < len; b++) begin
            seq++;
            push_beat(ch, {8'(ch), 24'(seq)}, b == len - 1);
        end
    endtask

    function automatic bit all_idle();
        for (int c = 0; c < NCH; c++) begin
            if (src_head[c] != src_tail[c]) return 1'b0;
        end
        return (exp_q.size() == 0) && (m_owner < 0);
    endfunction

    // One clock: check registered outputs, drive inputs, check ready, advance the model.
    task automatic step();
        logic [NCH-1:0] exp_rdy;
        bit             can_take;
        bit             eff_last;
        int             c;
        @(negedge clk);
        cyc++;
        chk("busy", busy, m_owner >= 0);
        chk("selector", selector, m_sel);
        chk("out_valid", out_valid, exp_q.size() != 0);
        if (exp_q.size() != 0) chk("out_beat", {out_last, out_data}, exp_q[0]);

        rst       = do_rst;
        out_ready = ($urandom_range(99) < rdy_pct);
        for (int ch = 0; ch < NCH; ch++) begin
            if (src_head[ch] != src_tail[ch]) begin
                ch_valid[ch] = ($urandom_range(99) < vld_pct);
                ch_data[ch]  = src_data[ch][src_head[ch] % DEPTH];
                ch_last[ch]  = src_last[ch][src_head[ch] % DEPTH];
            end else begin
                ch_valid[ch] = 1'b0;
                ch_data[ch]  = $urandom;
                ch_last[ch]  = 1'($urandom_range(1));
            end
        end
        #1;
        can_take = (exp_q.size() == 0) || out_ready;
        exp_rdy  = '0;
        if (m_owner >= 0 && can_take) exp_rdy[m_owner] = 1'b1;
        chk("ch_ready", ch_ready, exp_rdy);

        if (do_rst) begin
            m_owner = -1; m_ptr = 0; m_beats = 0; m_sel = 0;
            exp_q.delete();
            return;
        end

        if (out_valid && out_ready) begin
            out_log.push_back({out_last, out_data});
            out_cyc.push_back(cyc);
            if (chk_sel) chk("data_eq_sel", out_data, selector);
        end
        if (exp_q.size() != 0 && out_ready) void'(exp_q.pop_front());

        if (m_owner < 0) begin
            for (int k = 0; k < NCH; k++) begin
                c = (m_ptr + k) % NCH;
                if (ch_valid[c]) begin
                    m_owner = c;
                    m_sel   = c;
                    break;
                end
            end
        end else if (ch_valid[m_owner] && can_take) begin
            eff_last = ch_last[m_owner] || (m_beats == MB - 1);
            exp_q.push_back({eff_last, ch_data[m_owner]});
            src_head[m_owner]++;
            m_beats++;
            if (eff_last) begin
                m_ptr   = (m_owner + 1) % NCH;
                m_owner = -1;
                m_beats = 0;
            end
        end
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (!all_idle() && n < budget) begin
            step();
            n++;
        end
        chk("drain_in_budget", n < budget, 1'b1);
        step();
    endtask

    task automatic do_reset();
        do_rst = 1'b1;
        repeat (3) step();
        do_rst = 1'b0;
    endtask

    initial begin
        logic [DW:0] ent;
        logic [DW:0] exp5[11];
        logic [DW-1:0] held;
        int            n;

        for (int c = 0; c < NCH; c++) begin
            src_head[c] = 0;
            src_tail[c] = 0;
        end
        vecs[0] = '{mask: 8'hFF,        n: 8, order: '{0, 1, 2, 3, 4, 5, 6, 7}};
        vecs[1] = '{mask: 8'b1010_0100, n: 3, order: '{2, 5, 7, 0, 0, 0, 0, 0}};
        vecs[2] = '{mask: 8'b0000_0001, n: 1, order: '{0, 0, 0, 0, 0, 0, 0, 0}};
        vecs[3] = '{mask: 8'b1000_0001, n: 2, order: '{7, 0, 0, 0, 0, 0, 0, 0}};
        vecs[4] = '{mask: 8'b0100_0010, n: 2, order: '{1, 6, 0, 0, 0, 0, 0, 0}};
        vecs[5] = '{mask: 8'b0000_0110, n: 2, order: '{1, 2, 0, 0, 0, 0, 0, 0}};

        // Reset values
        do_reset();
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_last", out_last, 1'b0);
        chk("rst_selector", selector, 0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_ch_ready", ch_ready, 0);

        // Single channel, three-beat packet
        out_log.delete(); out_cyc.delete();
        push_beat(2, 32'hA0, 1'b0);
        push_beat(2, 32'hA1, 1'b0);
        push_beat(2, 32'hA2, 1'b1);
        drain(50);
        chk("single_count", out_log.size(), 3);
        if (out_log.size() == 3) begin
            chk("single_b0", out_log[0], {1'b0, 32'hA0});
            chk("single_b1", out_log[1], {1'b0, 32'hA1});
            chk("single_b2", out_log[2], {1'b1, 32'hA2});
            chk("single_back_to_back", out_cyc[2] - out_cyc[0], 2);
        end
        chk("single_selector", selector, 2);
        chk("single_busy_after", busy, 1'b0);

        // Fairness vector table, starting from pointer 0
        do_reset();
        chk_sel = 1'b1;
        for (int v = 0; v < 6; v++) begin
            out_log.delete(); out_cyc.delete();
            for (int c = 0; c < NCH; c++) begin
                if (vecs[v].mask[c]) push_beat(c, DW'(c), 1'b1);
            end
            drain(80);
            chk("rr_count", out_log.size(), vecs[v].n);
            n = (out_log.size() < vecs[v].n) ? out_log.size() : vecs[v].n;
            for (int k = 0; k < n; k++) begin
                ent = out_log[k];
                chk("rr_order", ent, {1'b1, 32'(vecs[v].order[k])});
            end
        end
        chk_sel = 1'b0;

        // Backpressure mid-packet
        out_log.delete(); out_cyc.delete();
        for (int b = 1; b <= 4; b++) push_beat(4, 32'h400 + 32'(b), b == 4);
        n = 0;
        while (!out_valid && n < 10) begin
            step();
            n++;
        end
        chk("bp_first_beat_seen", out_valid, 1'b1);
        rdy_pct = 0;
        step();
        held = out_data;
        for (int k = 0; k < 5; k++) begin
            chk("bp_ready_low", ch_ready, 0);
            chk("bp_data_stable", out_data, held);
            chk("bp_valid_held", out_valid, 1'b1);
            if (k < 4) step();
        end
        rdy_pct = 100;
        drain(50);
        chk("bp_count", out_log.size(), 4);
        for (int k = 0; k < 4 && k < out_log.size(); k++) begin
            chk("bp_beat", out_log[k], {k == 3, 32'h401 + 32'(k)});
        end

        // Forced release at MAX_BURST with a competing requester
        out_log.delete(); out_cyc.delete();
        for (int b = 1; b <= 10; b++) push_beat(5, 32'h500 + 32'(b), b == 10);
        step();
        step();
        push_beat(6, 32'h600, 1'b1);
        drain(100);
        exp5 = '{{1'b0, 32'h501}, {1'b0, 32'h502}, {1'b0, 32'h503}, {1'b1, 32'h504},
                 {1'b1, 32'h600},
                 {1'b0, 32'h505}, {1'b0, 32'h506}, {1'b0, 32'h507}, {1'b1, 32'h508},
                 {1'b0, 32'h509}, {1'b1, 32'h50A}};
        chk("burst_count", out_log.size(), 11);
        for (int k = 0; k < 11 && k < out_log.size(); k++) chk("burst_beat", out_log[k], exp5[k]);

        // Reset mid-packet: pointer must restart at 0
        push_beat(2, 32'h200, 1'b1);
        drain(30);
        for (int b = 1; b <= 3; b++) push_beat(3, 32'h300 + 32'(b), b == 3);
        n = 0;
        while (!out_valid && n < 10) begin
            step();
            n++;
        end
        chk("rst_mid_first_beat", {out_valid, out_data}, {1'b1, 32'h301});
        push_beat(1, 32'h101, 1'b1);
        out_log.delete(); out_cyc.delete();
        do_rst = 1'b1;
        step();
        do_rst = 1'b0;
        step();
        chk("rst_mid_valid", out_valid, 1'b0);
        chk("rst_mid_busy", busy, 1'b0);
        step();
        chk("rst_mid_regrant", selector, 1);
        chk("rst_mid_busy2", busy, 1'b1);
        drain(50);
        chk("rst_mid_count", out_log.size(), 2);
        if (out_log.size() == 2) begin
            chk("rst_mid_b0", out_log[0], {1'b1, 32'h101});
            chk("rst_mid_b1", out_log[1], {1'b1, 32'h303});
        end

        // Randomized traffic against the model
        do_reset();
        rdy_pct = 60;
        vld_pct = 75;
        for (int r = 0; r < 6; r++) begin
            for (int p = 0; p < 6; p++) push_packet($urandom_range(NCH - 1), $urandom_range(1, 6));
            drain(2000);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
